// File: rtl/pcs_am_insert_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_am_insert_tx_if
//  Description : Block bus between the per-lane encoder/scrambler and the
//                alignment-marker inserter, plus the inserter's output toward
//                the TX gearbox. All lanes share one valid/ready pair.
//  Revision    : 1.0  initial release
// ============================================================================
interface pcs_am_insert_tx_if #(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 66
);
    logic                      valid_i;
    logic [LANE_N*BLOCK_W-1:0] data_i;
    logic                      ready_o;
    logic                      valid_o;
    logic                      am_o;
    logic [LANE_N*BLOCK_W-1:0] data_o;

    // Upstream/test side: offers blocks, observes the inserter output
    modport master (
        output valid_i,
        output data_i,
        input  ready_o,
        input  valid_o,
        input  am_o,
        input  data_o
    );

    // Inserter side
    modport slave (
        input  valid_i,
        input  data_i,
        output ready_o,
        output valid_o,
        output am_o,
        output data_o
    );
endinterface
`default_nettype wire

// File: rtl/pcs_am_insert_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_am_insert_tx
//  Description : Multi-lane alignment-marker inserter for the 40G/100G PCS TX
//                path. Every GAP_N accepted blocks the upstream is stalled for
//                one cycle and a lane-specific marker is emitted on all lanes.
//                Optional feature macro PCS_AM_BIP_EN: when defined, each
//                marker carries the running BIP-8 of its lane; otherwise the
//                BIP fields are fixed at BIP3=8'h00 / BIP7=8'hFF.
//  Revision    : 1.0  initial release
// ============================================================================
module pcs_am_insert_tx #(
    parameter int                   LANE_N  = 4,
    parameter int                   BLOCK_W = 66,
    parameter int                   GAP_N   = 16383,
    parameter logic [LANE_N*24-1:0] AM_VAL  = {24'h3D79A2, 24'h9B65C5,
                                               24'hE6C4F0, 24'h477690}
) (
    input  wire logic         clk,
    input  wire logic         nreset,
    pcs_am_insert_tx_if.slave bus
);

    localparam int                 c_cnt_w = $clog2(GAP_N + 1);
    localparam int                 c_w     = LANE_N * BLOCK_W;
    localparam logic [c_cnt_w-1:0] c_gap   = c_cnt_w'(GAP_N);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_valid;
    logic               r_am;
    logic [c_w-1:0]     r_data;
    logic [c_w-1:0]     w_marker;
    logic               w_mark;
    logic               w_accept;

`ifdef PCS_AM_BIP_EN
    // Byte-interleaved even parity over the payload; header bit 0 folds into
    // BIP bit 3 and header bit 1 into BIP bit 4.
    function automatic logic [7:0] bip_of(input logic [BLOCK_W-1:0] blk);
        logic [7:0] acc;
        acc = 8'h00;
        for (int j = 0; j < 8; j++) begin
            acc ^= blk[2 + 8*j +: 8];
        end
        acc[3] ^= blk[0];
        acc[4] ^= blk[1];
        return acc;
    endfunction
`endif

    // Slot 0 is the marker slot; ready depends on the slot counter only
    assign w_mark      = (r_cnt == '0);
    assign w_accept    = !w_mark && bus.valid_i;
    assign bus.ready_o = !w_mark;
    assign bus.valid_o = r_valid;
    assign bus.am_o    = r_am;
    assign bus.data_o  = r_data;

    genvar gi;
    generate
        for (gi = 0; gi < LANE_N; gi++) begin : g_lane
            logic [7:0]         w_m0;
            logic [7:0]         w_m1;
            logic [7:0]         w_m2;
            logic [7:0]         w_bip3;
            logic [BLOCK_W-1:0] w_blk;

            assign w_m0  = AM_VAL[24*gi      +: 8];
            assign w_m1  = AM_VAL[24*gi + 8  +: 8];
            assign w_m2  = AM_VAL[24*gi + 16 +: 8];
            // Control header 01, identifier bytes, BIP3, then their complements
            assign w_blk = {~w_bip3, ~w_m2, ~w_m1, ~w_m0,
                            w_bip3, w_m2, w_m1, w_m0, 2'b01};
            assign w_marker[BLOCK_W*gi +: BLOCK_W] = w_blk;

`ifdef PCS_AM_BIP_EN
            logic [7:0] r_bip;

            // Restart the lane parity with the marker's own bits, then fold in each accepted block
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_bip <= 8'h00;
                end else if (w_mark) begin
                    r_bip <= bip_of(w_blk);
                end else if (w_accept) begin
                    r_bip <= r_bip ^ bip_of(bus.data_i[BLOCK_W*gi +: BLOCK_W]);
                end
            end

            // The marker reports the window closed by this marker, i.e. the pre-update value
            assign w_bip3 = r_bip;
`else
            assign w_bip3 = 8'h00;
`endif
        end
    endgenerate

    // Slot counter: idle data slots hold, the last data slot wraps to the marker slot
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else if (w_mark) begin
            r_cnt <= c_one;
        end else if (bus.valid_i) begin
            r_cnt <= (r_cnt == c_gap) ? '0 : r_cnt + c_one;
        end
    end

    // Output register: marker on the marker slot, accepted block otherwise, bubble when idle
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_valid <= 1'b0;
            r_am    <= 1'b0;
            r_data  <= '0;
        end else if (w_mark) begin
            r_valid <= 1'b1;
            r_am    <= 1'b1;
            r_data  <= w_marker;
        end else if (bus.valid_i) begin
            r_valid <= 1'b1;
            r_am    <= 1'b0;
            r_data  <= bus.data_i;
        end else begin
            r_valid <= 1'b0;
            r_am    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcs_am_insert_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcs_am_insert_tx
//  Description : Directed self-checking bench for pcs_am_insert_tx with a
//                short marker gap (GAP_N=4) on four lanes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pcs_am_insert_tx;

    localparam int LANE_N  = 4;
    localparam int BLOCK_W = 66;
    localparam int GAP_N   = 4;
    localparam int W       = LANE_N * BLOCK_W;

`ifdef PCS_AM_BIP_EN
    localparam bit BIP_EN = 1'b1;
`else
    localparam bit BIP_EN = 1'b0;
`endif

    // Lane identifiers of the 40G table, lane 0 in the low byte
    localparam logic [31:0] M0 = {8'hA2, 8'hC5, 8'hF0, 8'h90};
    localparam logic [31:0] M1 = {8'h79, 8'h65, 8'hC4, 8'h76};
    localparam logic [31:0] M2 = {8'h3D, 8'h9B, 8'hE6, 8'h47};

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    pcs_am_insert_tx_if #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W)) bus ();

    pcs_am_insert_tx #(
        .LANE_N (LANE_N),
        .BLOCK_W(BLOCK_W),
        .GAP_N  (GAP_N)
    ) dut (
        .clk   (clk),
        .nreset(nreset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] exp_marker(input logic [LANE_N-1:0][7:0] bip);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < LANE_N; i++) begin
            v[BLOCK_W*i +: BLOCK_W] = {~bip[i], ~M2[8*i +: 8], ~M1[8*i +: 8], ~M0[8*i +: 8],
                                       bip[i], M2[8*i +: 8], M1[8*i +: 8], M0[8*i +: 8], 2'b01};
        end
        return v;
    endfunction

    function automatic logic [7:0] blk_bip(input logic [BLOCK_W-1:0] b);
        logic [7:0] a;
        a = 8'h00;
        for (int j = 0; j < 8; j++) begin
            a = a ^ b[2 + 8*j +: 8];
        end
        a[3] = a[3] ^ b[0];
        a[4] = a[4] ^ b[1];
        return a;
    endfunction

    function automatic logic [W-1:0] rand_blocks();
        logic [W-1:0] v;
        logic [95:0]  r;
        v = '0;
        for (int i = 0; i < LANE_N; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            v[BLOCK_W*i +: BLOCK_W] = r[BLOCK_W-1:0];
        end
        return v;
    endfunction

    initial begin
        logic [W-1:0]              zblk;
        logic [W-1:0]              cur;
        logic [W-1:0]              exp_d;
        logic                      exp_am;
        logic [LANE_N-1:0][7:0]    acc;
        logic [BLOCK_W-1:0]        seq_blk [7];
        logic                      seq_v   [7];
        int                        tb_cnt;

        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        zblk        = {LANE_N{66'h2}};

        // ---- reset state ----
        tick();
        tick();
        chk("rst_valid", W'(bus.valid_o), W'(1'b0));
        chk("rst_am",    W'(bus.am_o),    W'(1'b0));
        chk("rst_data",  bus.data_o,      '0);
        chk("rst_ready", W'(bus.ready_o), W'(1'b0));

        // ---- release: marker slot comes first, upstream stalled ----
        @(negedge clk);
        nreset      = 1'b1;
        bus.valid_i = 1'b1;
        bus.data_i  = zblk;
        #1;
        chk("mk0_ready_pre", W'(bus.ready_o), W'(1'b0));
        tick();
        chk("mk0_valid", W'(bus.valid_o), W'(1'b1));
        chk("mk0_am",    W'(bus.am_o),    W'(1'b1));
        chk("mk0_lane0", W'(bus.data_o[65:0]),
            W'({8'hFF, 8'hB8, 8'h89, 8'h6F, 8'h00, 8'h47, 8'h76, 8'h90, 2'b01}));
        chk("mk0_lane1_ids", W'(bus.data_o[66+25:66+2]), W'(24'hE6C4F0));
        chk("mk0_all",   bus.data_o, exp_marker('0));
        chk("mk0_ready_post", W'(bus.ready_o), W'(1'b1));

        // ---- four zero-payload data blocks (header 10) ----
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("z_valid", W'(bus.valid_o), W'(1'b1));
            chk("z_am",    W'(bus.am_o),    W'(1'b0));
            chk("z_data",  bus.data_o,      zblk);
            chk("z_ready", W'(bus.ready_o), W'(k != 3));
        end
        // Marker must appear even with nothing offered upstream
        bus.valid_i = 1'b0;
        tick();
        chk("mk1_am",   W'(bus.am_o),    W'(1'b1));
        chk("mk1_valid", W'(bus.valid_o), W'(1'b1));
        chk("mk1_data", bus.data_o, exp_marker({LANE_N{BIP_EN ? 8'h08 : 8'h00}}));

        // ---- idle-interleaved window: 4 accepted blocks over 7 cycles ----
        seq_blk[0] = {64'h0000_0000_0000_0001, 2'b10};
        seq_blk[1] = {66{1'b1}};
        seq_blk[2] = {64'h0000_0000_0000_0300, 2'b10};
        seq_blk[3] = {66{1'b1}};
        seq_blk[4] = {64'hFF00_0000_0000_0000, 2'b01};
        seq_blk[5] = {66{1'b1}};
        seq_blk[6] = {64'h0000_0000_0000_0000, 2'b01};
        for (int k = 0; k < 7; k++) seq_v[k] = (k % 2 == 0);
        for (int k = 0; k < 7; k++) begin
            bus.valid_i = seq_v[k];
            bus.data_i  = {LANE_N{seq_blk[k]}};
            tick();
            chk("idle_valid", W'(bus.valid_o), W'(seq_v[k]));
            chk("idle_am",    W'(bus.am_o),    W'(1'b0));
            if (seq_v[k]) chk("idle_data", bus.data_o, {LANE_N{seq_blk[k]}});
        end
        chk("idle_ready_end", W'(bus.ready_o), W'(1'b0));
        bus.valid_i = 1'b0;
        tick();
        chk("mk2_am",   W'(bus.am_o), W'(1'b1));
        chk("mk2_data", bus.data_o, exp_marker({LANE_N{BIP_EN ? 8'hF5 : 8'h00}}));

        // ---- streaming random blocks against a scoreboard ----
        tb_cnt      = 1;
        acc         = {LANE_N{BIP_EN ? 8'h08 : 8'h00}};
        cur         = rand_blocks();
        bus.valid_i = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            bus.data_i = cur;
            if (tb_cnt == 0) begin
                exp_d  = exp_marker(acc);
                exp_am = 1'b1;
                acc    = {LANE_N{BIP_EN ? 8'h08 : 8'h00}};
                tb_cnt = 1;
            end else begin
                exp_d  = cur;
                exp_am = 1'b0;
                if (BIP_EN) begin
                    for (int i = 0; i < LANE_N; i++)
                        acc[i] = acc[i] ^ blk_bip(cur[BLOCK_W*i +: BLOCK_W]);
                end
                tb_cnt = (tb_cnt == GAP_N) ? 0 : tb_cnt + 1;
                cur    = rand_blocks();
            end
            tick();
            chk("rnd_valid", W'(bus.valid_o), W'(1'b1));
            chk("rnd_am",    W'(bus.am_o),    W'(exp_am));
            chk("rnd_data",  bus.data_o,      exp_d);
            chk("rnd_ready", W'(bus.ready_o), W'(tb_cnt != 0));
        end

        // ---- asynchronous reset mid-gap (slot counter at 2) ----
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_valid", W'(bus.valid_o), W'(1'b0));
        chk("arst_am",    W'(bus.am_o),    W'(1'b0));
        chk("arst_data",  bus.data_o,      '0);
        chk("arst_ready", W'(bus.ready_o), W'(1'b0));
        @(negedge clk);
        nreset      = 1'b1;
        bus.valid_i = 1'b1;
        bus.data_i  = zblk;
        #1;
        chk("arst_ready_rel", W'(bus.ready_o), W'(1'b0));
        tick();
        chk("arst_mk_am",   W'(bus.am_o), W'(1'b1));
        chk("arst_mk_data", bus.data_o,   exp_marker('0));
        tick();
        chk("arst_d_am",   W'(bus.am_o), W'(1'b0));
        chk("arst_d_data", bus.data_o,   zblk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
